// File: rtl/dds_pkg.sv
// Shared widths, parameter bundle and CLK-side handshake states
// for the DDS parameter clock-domain crossing.
package dds_pkg;

    localparam int unsigned DEF_FREQ_W = 48;
    localparam int unsigned DEF_RATE_W = 32;

    typedef struct packed {
        logic [DEF_FREQ_W-1:0] freq;
        logic [DEF_FREQ_W-1:0] delta_freq;
        logic [DEF_RATE_W-1:0] delta_rate;
    } dds_param_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_WAIT_REL,
        S_WAIT_ACKLO
    } cdc_src_state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit synchronizer: a SYNC_STAGES-deep flip-flop chain in the destination clock.
module cdc_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic D,
    output logic Q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge CLK) begin
        chain <= {chain[SYNC_STAGES-2:0], D};
    end

    assign Q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/dds_param_cdc.sv
// Carries DDS chirp parameters from CLK into DDS_CLK under a four-phase REQ/ACK handshake.
// Define DDS_PARAM_CDC_CNT_EN to add the XFER_CNT transfer counter and OVR overrun flag.
module dds_param_cdc
    import dds_pkg::*;
#(
    parameter int unsigned FREQ_W      = DEF_FREQ_W,
    parameter int unsigned RATE_W      = DEF_RATE_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DDS_CLK,
    input  logic              REQ,
    output logic              ACK,
    input  logic [FREQ_W-1:0] I_FREQ,
    input  logic [FREQ_W-1:0] I_DELTA_FREQ,
    input  logic [RATE_W-1:0] I_DELTA_RATE,
    input  logic              I_START,
    output logic              BUSY,
`ifdef DDS_PARAM_CDC_CNT_EN
    output logic [15:0]       XFER_CNT,
    output logic              OVR,
`endif
    output logic [FREQ_W-1:0] O_FREQ,
    output logic [FREQ_W-1:0] O_DELTA_FREQ,
    output logic [RATE_W-1:0] O_DELTA_RATE,
    output logic              O_LOAD,
    output logic              O_START
);

    cdc_src_state_e state, state_nxt;
    dds_param_t     hold, hold_nxt;
    logic           req_lvl, req_lvl_nxt;
    logic           ack_nxt, busy_nxt;
    logic           ack_sync;

    logic           rst_dds, req_sync, req_sync_q, req_rise, start_sync;
    logic           ack_lvl, params_valid;
    dds_param_t     o_param;

    // CLK-side state and hold registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            hold    <= '0;
            req_lvl <= 1'b0;
            ACK     <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_nxt;
            hold    <= hold_nxt;
            req_lvl <= req_lvl_nxt;
            ACK     <= ack_nxt;
            BUSY    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold;
        req_lvl_nxt = req_lvl;
        ack_nxt     = ACK;
        busy_nxt    = BUSY;
        case (state)
            S_IDLE: begin
                if (REQ) begin
                    hold_nxt.freq       = I_FREQ;
                    hold_nxt.delta_freq = I_DELTA_FREQ;
                    hold_nxt.delta_rate = I_DELTA_RATE;
                    req_lvl_nxt         = 1'b1;
                    busy_nxt            = 1'b1;
                    state_nxt           = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (ack_sync) begin
                    ack_nxt   = 1'b1;
                    state_nxt = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (!REQ) begin
                    req_lvl_nxt = 1'b0;
                    state_nxt   = S_WAIT_ACKLO;
                end
            end
            S_WAIT_ACKLO: begin
                if (!ack_sync) begin
                    ack_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

`ifdef DDS_PARAM_CDC_CNT_EN
    logic xfer_done;

    assign xfer_done = (state == S_WAIT_ACKLO) && !ack_sync;

    // REQ already high as the previous transfer closes means it re-rose before ACK fell
    always_ff @(posedge CLK) begin
        if (RESET) begin
            XFER_CNT <= '0;
            OVR      <= 1'b0;
        end else if (xfer_done) begin
            XFER_CNT <= XFER_CNT + 16'd1;
            if (REQ) begin
                OVR <= 1'b1;
            end
        end
    end
`endif

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rst (
        .CLK (DDS_CLK),
        .D   (RESET),
        .Q   (rst_dds)
    );

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
        .CLK (DDS_CLK),
        .D   (req_lvl),
        .Q   (req_sync)
    );

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
        .CLK (DDS_CLK),
        .D   (I_START),
        .Q   (start_sync)
    );

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
        .CLK (CLK),
        .D   (ack_lvl),
        .Q   (ack_sync)
    );

    assign req_rise = req_sync & ~req_sync_q;

    // Hold registers have been stable for SYNC_STAGES DDS cycles when req_rise samples them.
    // req_sync_q clears in reset so a request already pending at release is still seen.
    always_ff @(posedge DDS_CLK) begin
        if (rst_dds) begin
            req_sync_q   <= 1'b0;
            o_param      <= '0;
            O_LOAD       <= 1'b0;
            O_START      <= 1'b0;
            params_valid <= 1'b0;
            ack_lvl      <= 1'b0;
        end else begin
            req_sync_q <= req_sync;
            O_LOAD     <= req_rise;
            O_START    <= start_sync & (params_valid | req_rise);
            if (req_rise) begin
                o_param      <= hold;
                params_valid <= 1'b1;
                ack_lvl      <= 1'b1;
            end else if (!req_sync) begin
                ack_lvl <= 1'b0;
            end
        end
    end

    assign O_FREQ       = o_param.freq;
    assign O_DELTA_FREQ = o_param.delta_freq;
    assign O_DELTA_RATE = o_param.delta_rate;

endmodule

// File: tb/tb_dds_param_cdc.sv
// Bench for dds_param_cdc: every issued transfer is queued and the DDS-side outputs are
// compared against the queue-driven model each DDS_CLK cycle, plus literal spot checks.
module tb_dds_param_cdc;
    import dds_pkg::*;

    localparam int CLK_HALF = 10417;
    localparam int CLK_PER  = 2 * CLK_HALF;

    logic CLK = 1'b0, DDS_CLK = 1'b0, RESET = 1'b1, REQ = 1'b0, I_START = 1'b0;
    logic ACK, BUSY, O_LOAD, O_START;
    logic [DEF_FREQ_W-1:0] I_FREQ = '0, I_DELTA_FREQ = '0, O_FREQ, O_DELTA_FREQ;
    logic [DEF_RATE_W-1:0] I_DELTA_RATE = '0, O_DELTA_RATE;
`ifdef DDS_PARAM_CDC_CNT_EN
    logic [15:0] XFER_CNT;
    logic        OVR;
`endif

    int dds_half = 4167;
    always #(CLK_HALF) CLK = ~CLK;
    always #(dds_half) DDS_CLK = ~DDS_CLK;

    dds_param_cdc #(.FREQ_W(DEF_FREQ_W), .RATE_W(DEF_RATE_W), .SYNC_STAGES(2)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .DDS_CLK      (DDS_CLK),
        .REQ          (REQ),
        .ACK          (ACK),
        .I_FREQ       (I_FREQ),
        .I_DELTA_FREQ (I_DELTA_FREQ),
        .I_DELTA_RATE (I_DELTA_RATE),
        .I_START      (I_START),
        .BUSY         (BUSY),
`ifdef DDS_PARAM_CDC_CNT_EN
        .XFER_CNT     (XFER_CNT),
        .OVR          (OVR),
`endif
        .O_FREQ       (O_FREQ),
        .O_DELTA_FREQ (O_DELTA_FREQ),
        .O_DELTA_RATE (O_DELTA_RATE),
        .O_LOAD       (O_LOAD),
        .O_START      (O_START)
    );

    int         n_cmp = 0, n_bad = 0;
    int         load_cnt = 0, n_issued = 0;
    longint     load_t = 0;
    dds_param_t exp_q[$];
    dds_param_t cur_exp = '0;
    bit         rst_window = 1'b1, start_stable = 1'b1, loaded_any = 1'b0;
    bit         abort = 1'b0, start_at_load = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: loads consume issued transfers in order; outputs hold the last consumed one
    always @(negedge DDS_CLK) begin
        if (!rst_window) begin
            if (O_LOAD) begin
                load_cnt++;
                load_t        = $time;
                loaded_any    = 1'b1;
                start_at_load = O_START;
                chk("load_has_req", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
            end
            chk("o_freq", 64'(O_FREQ), 64'(cur_exp.freq));
            chk("o_delta_freq", 64'(O_DELTA_FREQ), 64'(cur_exp.delta_freq));
            chk("o_delta_rate", 64'(O_DELTA_RATE), 64'(cur_exp.delta_rate));
            if (start_stable) chk("o_start", 64'(O_START), 64'(I_START & loaded_any));
        end
    end

    task automatic issue(input dds_param_t p);
        I_FREQ       = p.freq;
        I_DELTA_FREQ = p.delta_freq;
        I_DELTA_RATE = p.delta_rate;
        REQ          = 1'b1;
        exp_q.push_back(p);
        n_issued++;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (ACK !== lvl && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk(name, 64'(ACK), 64'(lvl));
        if (ACK !== lvl) abort = 1'b1;
    endtask

    task automatic xfer(input dds_param_t p, input bit poke);
        int l0;
        if (abort) return;
        l0 = load_cnt;
        @(negedge CLK);
        issue(p);
        wait_ack(1'b1, "ack_rise");
        if (abort) return;
        chk("busy_in_xfer", 64'(BUSY), 64'd1);
        chk("ack_within_4clk", 64'(($time - load_t) <= 64'(4 * CLK_PER)), 64'd1);
        if (poke) I_FREQ = 48'hFFFF;
        @(negedge CLK);
        REQ = 1'b0;
        wait_ack(1'b0, "ack_fall");
        chk("one_load_per_xfer", 64'(load_cnt - l0), 64'd1);
    endtask

    function automatic dds_param_t rnd_param();
        dds_param_t p;
        p.freq       = DEF_FREQ_W'({$urandom(), $urandom()});
        p.delta_freq = DEF_FREQ_W'({$urandom(), $urandom()});
        p.delta_rate = $urandom();
        return p;
    endfunction

    initial begin
        #2000000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        dds_param_t p;
        repeat (10) @(negedge CLK);
        RESET      = 1'b0;
        rst_window = 1'b0;
        @(negedge CLK);
        chk("rst_ack", 64'(ACK), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_o_freq", 64'(O_FREQ), 64'd0);
        chk("rst_o_load", 64'(O_LOAD), 64'd0);
        chk("rst_o_start", 64'(O_START), 64'd0);

        // Run level raised before any parameters have been loaded
        start_stable = 1'b0;
        I_START      = 1'b1;
        repeat (4) @(negedge CLK);
        start_stable = 1'b1;
        repeat (4) @(negedge CLK);
        chk("start_before_load", 64'(O_START), 64'd0);

        p.freq       = 48'h123456789ABC;
        p.delta_freq = 48'h10;
        p.delta_rate = 32'h3E8;
        xfer(p, 1'b1);
        chk("first_o_freq", 64'(O_FREQ), 64'h123456789ABC);
        chk("first_o_delta_freq", 64'(O_DELTA_FREQ), 64'h10);
        chk("first_o_delta_rate", 64'(O_DELTA_RATE), 64'h3E8);
        chk("start_with_load", 64'(start_at_load), 64'd1);
        chk("first_load_count", 64'(load_cnt), 64'd1);

        p.freq       = 48'hFFFF_FFFF_FFFF;
        p.delta_freq = 48'h0;
        p.delta_rate = 32'hFFFF_FFFF;
        xfer(p, 1'b0);
        chk("ones_o_freq", 64'(O_FREQ), 64'hFFFF_FFFF_FFFF);
        chk("zero_o_delta_freq", 64'(O_DELTA_FREQ), 64'h0);

        // Reset while waiting for REQ release, REQ held through it
        p.freq       = 48'hA5A5_5A5A_0F0F;
        p.delta_freq = 48'h0000_0000_0777;
        p.delta_rate = 32'h1234_5678;
        @(negedge CLK);
        issue(p);
        wait_ack(1'b1, "rst_test_ack");
        @(negedge CLK);
        RESET      = 1'b1;
        rst_window = 1'b1;
        repeat (2) @(negedge CLK);
        chk("ack_in_reset", 64'(ACK), 64'd0);
        chk("busy_in_reset", 64'(BUSY), 64'd0);
        repeat (3) @(negedge CLK);
        chk("reset_o_freq", 64'(O_FREQ), 64'd0);
        chk("reset_o_delta_freq", 64'(O_DELTA_FREQ), 64'd0);
        chk("reset_o_delta_rate", 64'(O_DELTA_RATE), 64'd0);
        chk("reset_o_start", 64'(O_START), 64'd0);
        exp_q.delete();
        exp_q.push_back(p);
        n_issued++;
        cur_exp    = '0;
        loaded_any = 1'b0;
        RESET      = 1'b0;
        rst_window = 1'b0;
        wait_ack(1'b1, "post_rst_ack");
        @(negedge CLK);
        REQ = 1'b0;
        wait_ack(1'b0, "post_rst_ack_fall");
        chk("post_rst_o_freq", 64'(O_FREQ), 64'hA5A5_5A5A_0F0F);
        chk("post_rst_o_delta_rate", 64'(O_DELTA_RATE), 64'h1234_5678);

`ifdef DDS_PARAM_CDC_CNT_EN
        repeat (2) xfer(rnd_param(), 1'b0);
        chk("xfer_cnt_3", 64'(XFER_CNT), 64'd3);
        chk("ovr_clear", 64'(OVR), 64'd0);
        p = rnd_param();
        @(negedge CLK);
        issue(p);
        wait_ack(1'b1, "ovr_ack");
        @(negedge CLK);
        REQ = 1'b0;
        repeat (2) @(negedge CLK);
        issue(p);
        wait_ack(1'b0, "ovr_ack_fall");
        wait_ack(1'b1, "ovr_ack2");
        @(negedge CLK);
        REQ = 1'b0;
        wait_ack(1'b0, "ovr_ack2_fall");
        chk("ovr_set", 64'(OVR), 64'd1);
        chk("xfer_cnt_5", 64'(XFER_CNT), 64'd5);
`endif

        dds_half = 16667;
        for (int i = 0; i < 1000; i++) xfer(rnd_param(), 1'b0);
        dds_half = 2500;
        for (int i = 0; i < 1000; i++) xfer(rnd_param(), 1'b0);

        repeat (20) @(negedge CLK);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("loads_match_reqs", 64'(load_cnt), 64'(n_issued));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dds_param_cdc.md
# dds_param_cdc

Clock-domain crossing stage between the 48 MHz command/timing engine and the DDS chirp core. The block takes the DDS start frequency, frequency step and step rate from the CLK domain under a four-phase REQ/ACK handshake. It snapshots them in CLK, carries them into DDS_CLK and presents them with a one-cycle load strobe. It also carries the DDS_start level across, gated so the DDS never starts on parameters it has not yet loaded.

## Interface
- FREQ_W, 48: width of start frequency and frequency step.
- RATE_W, 32: width of step rate.
- SYNC_STAGES, 2: flip-flop count of every single-bit synchronizer; legal values 2..4.
- CLK  in  1  command-domain clock, 48 MHz.
- RESET  in  1  synchronous, active-high; clock CLK.
- DDS_CLK  in  1  DDS-domain clock, asynchronous to CLK.
- REQ  in  1  CLK; transfer request; data valid while high.
- ACK  out  1  CLK; transfer acknowledge.
- I_FREQ  in  FREQ_W  CLK; start frequency.
- I_DELTA_FREQ  in  FREQ_W  CLK; frequency step.
- I_DELTA_RATE  in  RATE_W  CLK; step rate.
- I_START  in  1  CLK; DDS run level.
- BUSY  out  1  CLK; high from snapshot until return to S_IDLE.
- O_FREQ, O_DELTA_FREQ, O_DELTA_RATE  out  FREQ_W/FREQ_W/RATE_W  DDS_CLK; loaded parameters.
- O_LOAD  out  1  DDS_CLK; one-cycle pulse when the O_* parameters update.
- O_START  out  1  DDS_CLK; synchronized I_START AND params_valid.

## Operation
- CLK-side FSM: S_IDLE, S_WAIT_ACK, S_WAIT_REL, S_WAIT_ACKLO.
  - S_IDLE: when REQ=1, snapshot the I_* inputs into hold registers, set req_lvl=1, and go to S_WAIT_ACK.
  - S_WAIT_ACK: when ack_sync=1, set ACK=1 and go to S_WAIT_REL.
  - S_WAIT_REL: when REQ=0, set req_lvl=0 and go to S_WAIT_ACKLO.
  - S_WAIT_ACKLO: when ack_sync=0, set ACK=0 and go to S_IDLE.
- Hold registers change only in S_IDLE. Input changes while REQ is high are ignored.
- DDS side:
  - On the rising edge of req_sync, copy the hold registers to O_*, pulse O_LOAD, set params_valid=1 and set ack_lvl=1.
  - On the falling edge of req_sync, clear ack_lvl.
- ack_lvl returns to CLK through an SYNC_STAGES synchronizer as ack_sync.
- I_START crosses through an SYNC_STAGES synchronizer. O_START = start_sync & params_valid.
- params_valid is cleared only by reset.
- A REQ pulse shorter than the handshake is still completed. Once captured, a request always finishes all four phases.

## Timing
- Reset values: ACK=0, BUSY=0, state S_IDLE, hold registers=0, req_lvl=0. In DDS_CLK: O_*=0, O_LOAD=0, O_START=0, params_valid=0, ack_lvl=0.
- DDS reset: RESET passes through an SYNC_STAGES synchronizer into DDS_CLK as rst_dds. It asserts after at most SYNC_STAGES+1 DDS_CLK cycles. RESET must be held at least SYNC_STAGES+2 DDS_CLK periods.
- Latency, REQ rise to O_LOAD: 1 CLK + SYNC_STAGES+1 DDS_CLK.
- Latency, O_LOAD to ACK rise: SYNC_STAGES+1 CLK.
- Latency, REQ fall to ACK fall: 1 CLK + SYNC_STAGES+1 DDS_CLK + SYNC_STAGES+1 CLK.
- Hold registers are stable for at least SYNC_STAGES DDS_CLK cycles before capture. This makes the multi-bit crossing safe; the hold→O_* paths carry a max-delay constraint.
- Reset mid-handshake: both FSMs return to idle and ACK=0. If REQ is still high on the first CLK cycle after reset, a new transfer starts.
- Simultaneous REQ rise and RESET: reset wins and nothing is captured.
- I_START high before the first load: O_START stays 0 until params_valid=1, then follows start_sync in the same cycle.

## Configuration
- DDS_PARAM_CDC_CNT_EN defined:
  - Adds XFER_CNT (out, 16, CLK), which increments on each S_WAIT_ACKLO→S_IDLE transition, wraps 0xFFFF→0, and resets to 0.
  - Adds OVR (out, 1, CLK), a sticky flag set when REQ is seen high in the cycle that state returns to S_IDLE while the previous transfer is unfinished. In practice this means REQ re-rose before ACK fell. Cleared by reset.
- Macro undefined: neither port exists and there is no counter logic.

## Structure
- The shared package dds_pkg holds:
  - FREQ_W and RATE_W defaults.
  - typedef dds_param_t, a struct {freq, delta_freq, delta_rate} used for the hold registers and O_* bundling.
  - typedef cdc_src_state_e, an enum of the four CLK-side states.
- One sub-module: cdc_sync_bit, a parameterized SYNC_STAGES flip-flop chain. It is instantiated for req, ack, start and reset.

## Test plan
- CLK 48 MHz, DDS_CLK 120 MHz, SYNC_STAGES=2. Drive I_FREQ=0x123456789ABC, I_DELTA_FREQ=0x10, I_DELTA_RATE=0x3E8 with REQ high. Required: O_LOAD fires once with exactly those values; ACK rises within 4 CLK of O_LOAD.
- After capture, change I_FREQ to 0xFFFF while REQ is still high. Required: O_FREQ keeps 0x123456789ABC.
- I_START high with no prior transfer. Required: O_START=0. Then complete a transfer: O_START=1 in the same DDS_CLK cycle as O_LOAD.
- Assert RESET for 5 CLK while in S_WAIT_REL. Required: ACK=0 and O_*=0. With REQ still high, a new transfer completes.
- Run 1000 back-to-back transfers with random data, DDS_CLK at 30 MHz and at 200 MHz. Required: every value is received in order and no O_LOAD occurs without a matching REQ.
- DDS_PARAM_CDC_CNT_EN: after 3 transfers XFER_CNT=3. Re-raising REQ before ACK falls sets OVR=1.
